// File: rtl/alu_instr_sequencer.sv
// Fetch + R-format ALU execute control-step sequencer for the single-bus datapath.
// Optional SEQ_SINGLE_STEP_EN adds a step input gating every non-IDLE transition.
module alu_instr_sequencer #(
    parameter int OPCODE_W    = 5,
    parameter int ALU_SEL_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 clr,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                 step,
`endif
    input  logic                 start,
    input  logic [OPCODE_W-1:0]  ir_opcode,
    input  logic                 mem_ready,
    output logic                 pc_out,
    output logic                 mar_in,
    output logic                 inc_pc,
    output logic                 z_in,
    output logic                 zlow_out,
    output logic                 pc_in,
    output logic                 mem_read,
    output logic                 mdr_in,
    output logic                 mdr_out,
    output logic                 ir_in,
    output logic                 y_in,
    output logic                 gra,
    output logic                 grb,
    output logic                 grc,
    output logic                 r_in,
    output logic                 r_out,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 fault
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_DONE
    } state_t;

    localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ALU_SEL_W-1:0] op_q, op_d;
    logic                 fault_q, fault_d;
    logic                 op_legal;
    logic [ALU_SEL_W-1:0] op_dec;
    logic                 adv;

`ifdef SEQ_SINGLE_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    always_comb begin
        op_legal = 1'b1;
        op_dec   = '0;
        unique case (ir_opcode)
            OPCODE_W'(0): op_dec = ALU_SEL_W'(0);
            OPCODE_W'(1): op_dec = ALU_SEL_W'(1);
            OPCODE_W'(2): op_dec = ALU_SEL_W'(2);
            OPCODE_W'(3): op_dec = ALU_SEL_W'(3);
            OPCODE_W'(4): op_dec = ALU_SEL_W'(4);
            OPCODE_W'(5): op_dec = ALU_SEL_W'(5);
            default:      op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fault_d = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !fault_q) begin
                    state_d = S_T0;
                    cnt_d   = '0;
                end
            end
            S_T0: if (adv) state_d = S_T1;
            S_T1: begin
                // mem_ready is checked first so it wins on the timeout edge
                if (adv) begin
                    if (mem_ready) begin
                        state_d = S_T2;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        fault_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_T2: if (adv) state_d = S_T3;
            S_T3: begin
                if (adv) begin
                    if (op_legal) begin
                        op_d    = op_dec;
                        state_d = S_T4;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_T4:   if (adv) state_d = S_T5;
            S_T5:   if (adv) state_d = S_DONE;
            S_DONE: if (adv) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        inc_pc   = 1'b0;
        z_in     = 1'b0;
        zlow_out = 1'b0;
        pc_in    = 1'b0;
        mem_read = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        gra      = 1'b0;
        grb      = 1'b0;
        grc      = 1'b0;
        r_in     = 1'b0;
        r_out    = 1'b0;
        alu_sel  = '0;
        unique case (1'b1)
            (state_q == S_T0): begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            (state_q == S_T1): begin
                // PC is loaded only on the first T1 cycle
                zlow_out = 1'b1;
                pc_in    = (cnt_q == 4'd0);
                mem_read = 1'b1;
                mdr_in   = 1'b1;
            end
            (state_q == S_T2): begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            (state_q == S_T3): begin
                grb   = op_legal;
                r_out = op_legal;
                y_in  = op_legal;
            end
            (state_q == S_T4): begin
                grc     = 1'b1;
                r_out   = 1'b1;
                z_in    = 1'b1;
                alu_sel = op_q;
            end
            (state_q == S_T5): begin
                zlow_out = 1'b1;
                gra      = 1'b1;
                r_in     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign fault = fault_q;

endmodule
